// File: rtl/demux_router_pkg.sv
// demux_router shared package: constants and small helpers
// for the registered 1:N word router.
package demux_router_pkg;

   localparam int DROP_CNT_W = 8;

   function automatic logic [DROP_CNT_W-1:0] sat_inc(
      input logic [DROP_CNT_W-1:0] v
   );
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// demux_chan_reg: one-entry holding register for a single
// output channel of demux_router.
module demux_chan_reg #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             ready,
   output logic [WIDTH-1:0] q,
   output logic             valid
);

   // A load always wins over a drain, so a word taken and a word
   // arriving on the same edge leave the register full.
   always_ff @(posedge clk) begin
      if (reset) begin
         q     <= '0;
         valid <= 1'b0;
      end else if (load) begin
         q     <= d;
         valid <= 1'b1;
      end else if (valid & ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/demux_router.sv
// demux_router: registered 1:CHANNELS word router with broadcast,
// valid/ready handshake and out-of-range drop accounting.
`ifndef DR_SLICE
`define DR_SLICE(i, w) (i)*(w) +: (w)
`endif

module demux_router
   import demux_router_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 16,
   parameter int SEL_W    = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [WIDTH-1:0]          in_data,
   input  logic [SEL_W-1:0]          in_sel,
   input  logic                      in_bcast,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic [CHANNELS-1:0]       out_valid,
   input  logic [CHANNELS-1:0]       out_ready,
   output logic                      err_sel,
   output logic [DROP_CNT_W-1:0]     drop_count
);

   if (2**SEL_W < CHANNELS) begin : g_sel_chk
      $fatal(1, "demux_router: SEL_W too narrow for CHANNELS");
   end
   if (CHANNELS < 2 || CHANNELS > 64) begin : g_ch_chk
      $fatal(1, "demux_router: CHANNELS must be 2..64");
   end

   logic [CHANNELS-1:0] free;
   logic [CHANNELS-1:0] uni_hit;
   logic [CHANNELS-1:0] load;
   logic                sel_ok;
   logic                acc;
   logic                drop;

   assign free   = ~out_valid | out_ready;
   assign sel_ok = 32'(in_sel) < 32'(CHANNELS);

   always_comb begin
      uni_hit = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         uni_hit[i] = !in_bcast && (32'(in_sel) == 32'(i));
      end
   end

   // Out-of-range unicasts are always accepted so a bad select
   // can never wedge the producer.
   always_comb begin
      in_ready = 1'b0;
      unique case (1'b1)
         reset:
            in_ready = 1'b0;
         !reset && in_bcast:
            in_ready = &free;
         !reset && !in_bcast && sel_ok:
            in_ready = |(uni_hit & free);
         !reset && !in_bcast && !sel_ok:
            in_ready = 1'b1;
         default:
            in_ready = 1'b0;
      endcase
   end

   assign acc  = in_valid & in_ready;
   assign drop = acc & !in_bcast & !sel_ok;
   assign load = {CHANNELS{acc}} &
                 (uni_hit | {CHANNELS{in_bcast}});

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      demux_chan_reg #(
         .WIDTH (WIDTH)
      ) u_reg (
         .clk   (clk),
         .reset (reset),
         .load  (load[g]),
         .d     (in_data),
         .ready (out_ready[g]),
         .q     (out_data[`DR_SLICE(g, WIDTH)]),
         .valid (out_valid[g])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_sel    <= 1'b0;
         drop_count <= '0;
      end else begin
         err_sel <= drop;
         if (drop) begin
            drop_count <= sat_inc(drop_count);
         end
      end
   end

endmodule

// File: tb/tb_demux_router.sv
// tb_demux_router: table-driven and scoreboard checks for
// demux_router at 16 and 12 channels.
module tb_demux_router;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset    = 1'b1;
   logic [15:0]   in_data  = '0;
   logic [3:0]    in_sel   = '0;
   logic          in_bcast = 1'b0;

   logic          v16 = 1'b0;
   logic          rdy16;
   logic [255:0]  od16;
   logic [15:0]   ov16;
   logic [15:0]   or16 = '0;
   logic          err16;
   logic [7:0]    cnt16;

   logic          v12 = 1'b0;
   logic          rdy12;
   logic [191:0]  od12;
   logic [11:0]   ov12;
   logic [11:0]   or12 = '0;
   logic          err12;
   logic [7:0]    cnt12;

   demux_router #(
      .WIDTH(16), .CHANNELS(16), .SEL_W(4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_bcast   (in_bcast),
      .in_valid   (v16),
      .in_ready   (rdy16),
      .out_data   (od16),
      .out_valid  (ov16),
      .out_ready  (or16),
      .err_sel    (err16),
      .drop_count (cnt16)
   );

   demux_router #(
      .WIDTH(16), .CHANNELS(12), .SEL_W(4)
   ) dut12 (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_bcast   (in_bcast),
      .in_valid   (v12),
      .in_ready   (rdy12),
      .out_data   (od12),
      .out_valid  (ov12),
      .out_ready  (or12),
      .err_sel    (err12),
      .drop_count (cnt12)
   );

   typedef struct {
      logic        v;
      logic        b;
      logic [3:0]  s;
      logic [15:0] d;
      logic [15:0] ordy;
      logic        er;
      logic [15:0] eov;
   } vec_t;

   vec_t        tbl[12];
   logic [15:0] sbq[16][$];
   logic [11:0] m12_v   = '0;
   logic        m12_err = 1'b0;
   int          m12_cnt = 0;
   bit          track   = 1'b0;
   logic [15:0] exp_next;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step16(input vec_t t, input bit use_tbl);
      logic [15:0] fr;
      logic        er;
      logic        acc;
      logic [15:0] pv;
      @(negedge clk);
      v16 = t.v; in_bcast = t.b; in_sel = t.s;
      in_data = t.d; or16 = t.ordy;
      v12 = 1'b0; or12 = '0;
      #1;
      for (int i = 0; i < 16; i++) begin
         fr[i] = (sbq[i].size() == 0) || t.ordy[i];
         chk("out_valid16", ov16[i], sbq[i].size() != 0);
         if (sbq[i].size() != 0)
            chk("out_data16", od16[i*16 +: 16], sbq[i][0]);
      end
      if (track && ov16[0] && or16[0]) begin
         chk("stream_order", od16[15:0], exp_next);
         exp_next++;
      end
      er = t.b ? &fr : fr[t.s];
      chk("in_ready16", rdy16, er);
      if (use_tbl) begin
         chk("tbl_ready", rdy16, t.er);
         chk("tbl_valid", ov16, t.eov);
      end
      acc = t.v & er;
      @(posedge clk);
      for (int i = 0; i < 16; i++) begin
         if (sbq[i].size() != 0 && t.ordy[i])
            pv = sbq[i].pop_front();
         if (acc && (t.b || t.s == i))
            sbq[i].push_back(t.d);
      end
   endtask

   task automatic step12(input logic v, input logic b,
                         input logic [3:0] s,
                         input logic [15:0] d,
                         input logic [11:0] ordy);
      logic [11:0] fr;
      logic [11:0] ld;
      logic        er;
      logic        acc;
      logic        sok;
      @(negedge clk);
      v12 = v; in_bcast = b; in_sel = s;
      in_data = d; or12 = ordy;
      v16 = 1'b0; or16 = '0;
      #1;
      fr  = ~m12_v | ordy;
      sok = (s < 4'd12);
      er  = 1'b1;
      if (b) er = &fr;
      else
         for (int i = 0; i < 12; i++)
            if (s == i) er = fr[i];
      chk("in_ready12", rdy12, er);
      acc = v & er;
      for (int i = 0; i < 12; i++)
         ld[i] = acc & (b | (s == i));
      @(posedge clk);
      #1;
      m12_v   = ld | (m12_v & ~ordy);
      m12_err = acc & !b & !sok;
      if (m12_err && m12_cnt != 255) m12_cnt++;
      chk("out_valid12", ov12, m12_v);
      chk("err_sel12", err12, m12_err);
      chk("drop_count12", cnt12, m12_cnt);
      if (acc && b)
         for (int i = 0; i < 12; i++)
            chk("bcast12_data", od12[i*16 +: 16], d);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; v16 = 1'b1; v12 = 1'b1;
      in_bcast = 1'b0; in_sel = 4'd13; in_data = 16'hDEAD;
      or16 = '0; or12 = '0;
      #1;
      chk("rst_ready16", rdy16, 1'b0);
      chk("rst_ready12", rdy12, 1'b0);
      @(posedge clk);
      for (int i = 0; i < 16; i++) sbq[i].delete();
      m12_v = '0; m12_err = 1'b0; m12_cnt = 0;
      @(negedge clk);
      reset = 1'b0; v16 = 1'b0; v12 = 1'b0;
      #1;
      chk("rst_valid16", ov16, 16'h0);
      chk("rst_data16", |od16, 1'b0);
      chk("rst_err16", err16, 1'b0);
      chk("rst_cnt16", cnt16, 8'd0);
      chk("rst_valid12", ov12, 12'h0);
      chk("rst_data12", |od12, 1'b0);
      chk("rst_err12", err12, 1'b0);
      chk("rst_cnt12", cnt12, 8'd0);
   endtask

   initial begin
      vec_t t;
      tbl[0]  = '{1'b1, 1'b0, 4'd9, 16'hA5A5, 16'h0000, 1'b1, 16'h0000};
      tbl[1]  = '{1'b1, 1'b0, 4'd9, 16'h1111, 16'h0000, 1'b0, 16'h0200};
      tbl[2]  = '{1'b1, 1'b0, 4'd9, 16'h1234, 16'h0200, 1'b1, 16'h0200};
      tbl[3]  = '{1'b0, 1'b0, 4'd9, 16'h0000, 16'h0200, 1'b1, 16'h0200};
      tbl[4]  = '{1'b1, 1'b0, 4'd3, 16'h3333, 16'h0000, 1'b1, 16'h0000};
      tbl[5]  = '{1'b1, 1'b1, 4'd0, 16'hBEEF, 16'h0000, 1'b0, 16'h0008};
      tbl[6]  = '{1'b1, 1'b1, 4'd0, 16'hBEEF, 16'h0008, 1'b1, 16'h0008};
      tbl[7]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 16'hFFFF, 1'b1, 16'hFFFF};
      tbl[8]  = '{1'b1, 1'b1, 4'd5, 16'hCAFE, 16'h0000, 1'b1, 16'h0000};
      tbl[9]  = '{1'b1, 1'b0, 4'd2, 16'h2222, 16'hFFFF, 1'b1, 16'hFFFF};
      tbl[10] = '{1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b1, 16'h0004};
      tbl[11] = '{1'b0, 1'b0, 4'd0, 16'h0000, 16'hFFFF, 1'b1, 16'h0004};

      do_reset();

      for (int k = 0; k < 12; k++) step16(tbl[k], 1'b1);

      track    = 1'b1;
      exp_next = 16'h0001;
      for (int k = 1; k <= 16; k++) begin
         t = '{1'b1, 1'b0, 4'd0, 16'(k), 16'h0001, 1'b1, 16'h0};
         step16(t, 1'b0);
      end
      t = '{1'b0, 1'b0, 4'd0, 16'h0, 16'h0001, 1'b1, 16'h0};
      step16(t, 1'b0);
      step16(t, 1'b0);
      track = 1'b0;
      chk("stream_count", exp_next, 16'h0011);

      for (int k = 0; k < 3; k++)
         step12(1'b1, 1'b0, 4'd13, 16'h1300 + 16'(k), 12'h000);
      step12(1'b0, 1'b0, 4'd13, 16'h0, 12'h000);
      chk("drops_three", cnt12, 8'd3);
      step12(1'b1, 1'b0, 4'd11, 16'h0B0B, 12'h000);
      step12(1'b1, 1'b0, 4'd11, 16'h0C0C, 12'h000);
      step12(1'b1, 1'b1, 4'd13, 16'hB0B0, 12'h800);
      step12(1'b0, 1'b0, 4'd0, 16'h0, 12'hFFF);
      for (int k = 0; k < 260; k++)
         step12(1'b1, 1'b0, 4'd12 + 4'(k % 4), 16'(k), 12'h000);
      chk("drops_saturate", cnt12, 8'd255);

      t = '{1'b1, 1'b0, 4'd2, 16'h0202, 16'h0000, 1'b1, 16'h0};
      step16(t, 1'b0);
      t = '{1'b1, 1'b0, 4'd5, 16'h0505, 16'h0000, 1'b1, 16'h0};
      step16(t, 1'b0);
      t = '{1'b0, 1'b0, 4'd0, 16'h0, 16'h0000, 1'b1, 16'h0024};
      step16(t, 1'b1);
      do_reset();
      t = '{1'b1, 1'b0, 4'd7, 16'h7777, 16'h0000, 1'b1, 16'h0000};
      step16(t, 1'b1);
      t = '{1'b0, 1'b0, 4'd7, 16'h0, 16'h0080, 1'b1, 16'h0080};
      step16(t, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
